sync_fifo_param: RTL and testbench

- Parametrised synchronous single-clock FIFO, next generation of the CPU-side data FIFO.
- Configurable data width and depth.
- Provides correct full/empty detection via wrap-bit pointers, occupancy count, programmable almost-full/almost-empty thresholds and a synchronous flush.
- Sits between AXI-side bus logic and the CNN accelerator datapath as the general buffering primitive.

---
 rtl/sync_fifo_param.sv | 91 +++++++++
 tb/tb_sync_fifo_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock show-ahead FIFO with wrap-bit pointers
// Optional sticky overflow/underflow flags (ovf_o/udf_o) are built when SYNC_FIFO_ERR_FLAG_EN is defined.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ren_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              afull_o,
    output logic              aempty_o,
`ifdef SYNC_FIFO_ERR_FLAG_EN
    output logic              ovf_o,
    output logic              udf_o,
`endif
    output logic [ADDR_W:0]   count_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              wr_acc;
    logic              rd_acc;

    // Same low bits with differing wrap bits means the writer is a full lap ahead.
    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

    assign wr_acc = wen_i & ~full_o;
    assign rd_acc = ren_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && wr_acc) begin
            mem[wptr[ADDR_W-1:0]] <= data_i;
        end
    end

    assign data_o   = empty_o ? '0 : mem[rptr[ADDR_W-1:0]];
    assign afull_o  = (count_o >= PTR_W'(AFULL_TH));
    assign aempty_o = (count_o <= PTR_W'(AEMPTY_TH));

`ifdef SYNC_FIFO_ERR_FLAG_EN
    // Sticky until reset; a flush clears the data but keeps the error history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (wen_i && full_o && !flush_i) begin
                ovf_o <= 1'b1;
            end
            if (ren_i && empty_o && !flush_i) begin
                udf_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        wen_i;
    logic [31:0] data_i;
    logic        ren_i;
    logic [31:0] data_o;
    logic        full_o;
    logic        empty_o;
    logic        afull_o;
    logic        aempty_o;
    logic [4:0]  count_o;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic        ovf_o;
    logic        udf_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] wr_val;
    logic [31:0] rd_val;

    sync_fifo_param #(
        .DATA_W(32), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .wen_i(wen_i),
        .data_i(data_i),
        .ren_i(ren_i),
        .data_o(data_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .afull_o(afull_o),
        .aempty_o(aempty_o),
`ifdef SYNC_FIFO_ERR_FLAG_EN
        .ovf_o(ovf_o),
        .udf_o(udf_o),
`endif
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        flush_i = 1'b0;
        wen_i   = 1'b0;
        ren_i   = 1'b0;
        data_i  = '0;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; wen_i = 1'b0; ren_i = 1'b0; data_i = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        tick();

        check("rst_empty",  32'(empty_o),  32'd1);
        check("rst_full",   32'(full_o),   32'd0);
        check("rst_count",  32'(count_o),  32'd0);
        check("rst_data",   data_o,        32'h0);
        check("rst_aempty", 32'(aempty_o), 32'd1);
        check("rst_afull",  32'(afull_o),  32'd0);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_udf", 32'(udf_o), 32'd0);
`endif

        for (int i = 0; i < 16; i++) begin
            wen_i = 1'b1; data_i = 32'h100 + 32'(i);
            tick();
            check("fill_count",  32'(count_o),  32'(i + 1));
            check("fill_afull",  32'(afull_o),  32'((i + 1) >= 12));
            check("fill_aempty", 32'(aempty_o), 32'((i + 1) <= 2));
            check("fill_full",   32'(full_o),   32'((i + 1) == 16));
        end

        wen_i = 1'b1; data_i = 32'hDEAD;
        tick();
        check("ovfw_count", 32'(count_o), 32'd16);
        check("ovfw_full",  32'(full_o),  32'd1);
        check("ovfw_head",  data_o,       32'h100);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        check("ovf_set", 32'(ovf_o), 32'd1);
`endif

        for (int i = 0; i < 16; i++) begin
            check("drain_data", data_o, 32'h100 + 32'(i));
            ren_i = 1'b1;
            tick();
            check("drain_count",  32'(count_o),  32'(15 - i));
            check("drain_aempty", 32'(aempty_o), 32'((15 - i) <= 2));
        end
        check("drained_empty", 32'(empty_o), 32'd1);
        check("drained_data",  data_o,       32'h0);

        ren_i = 1'b1;
        tick();
        check("udfr_count", 32'(count_o), 32'd0);
        check("udfr_empty", 32'(empty_o), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        check("udf_set", 32'(udf_o), 32'd1);
`endif

        wr_val = 32'h200;
        rd_val = 32'h200;
        for (int i = 0; i < 8; i++) begin
            wen_i = 1'b1; data_i = wr_val; wr_val++;
            tick();
        end
        check("wrap_prefill", 32'(count_o), 32'd8);
        for (int i = 0; i < 40; i++) begin
            check("wrap_data", data_o, rd_val);
            rd_val++;
            wen_i = 1'b1; ren_i = 1'b1; data_i = wr_val; wr_val++;
            tick();
            check("wrap_count", 32'(count_o), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            check("wrap_tail", data_o, rd_val);
            rd_val++;
            ren_i = 1'b1;
            tick();
        end
        check("wrap_empty", 32'(empty_o), 32'd1);

        for (int i = 0; i < 16; i++) begin
            wen_i = 1'b1; data_i = 32'h300 + 32'(i);
            tick();
        end
        check("sim_full_pre", 32'(full_o), 32'd1);
        wen_i = 1'b1; ren_i = 1'b1; data_i = 32'hBEEF;
        tick();
        check("sim_full_count", 32'(count_o), 32'd15);
        check("sim_full_flag",  32'(full_o),  32'd0);
        for (int i = 1; i < 16; i++) begin
            check("sim_full_data", data_o, 32'h300 + 32'(i));
            ren_i = 1'b1;
            tick();
        end
        check("sim_full_nobeef", 32'(empty_o), 32'd1);

        wen_i = 1'b1; ren_i = 1'b1; data_i = 32'hAA;
        tick();
        check("sim_empty_count", 32'(count_o), 32'd1);
        check("sim_empty_data",  data_o,       32'hAA);
        check("sim_empty_flag",  32'(empty_o), 32'd0);
        ren_i = 1'b1;
        tick();
        check("sim_empty_pop", 32'(count_o), 32'd0);

        for (int i = 0; i < 5; i++) begin
            wen_i = 1'b1; data_i = 32'h400 + 32'(i);
            tick();
        end
        check("flush_pre", 32'(count_o), 32'd5);
        flush_i = 1'b1; wen_i = 1'b1; data_i = 32'h555;
        tick();
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_empty", 32'(empty_o), 32'd1);
        check("flush_data",  data_o,       32'h0);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        check("flush_keep_ovf", 32'(ovf_o), 32'd1);
        check("flush_keep_udf", 32'(udf_o), 32'd1);
`endif
        wen_i = 1'b1; data_i = 32'h600;
        tick();
        check("post_flush_data",  data_o,       32'h600);
        check("post_flush_count", 32'(count_o), 32'd1);

        rst = 1'b1; wen_i = 1'b1; data_i = 32'h777;
        tick();
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_empty", 32'(empty_o), 32'd1);
        check("mid_rst_data",  data_o,       32'h0);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        check("mid_rst_ovf", 32'(ovf_o), 32'd0);
        check("mid_rst_udf", 32'(udf_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
